data_mem_ctrl: RTL and testbench

Parametrised data memory for the pipelined CPU's MEM stage: the successor of the fixed 128-word data RAM. It adds byte, halfword and word access with little-endian lanes, sign- or zero-extended loads, and a registered read path with a valid/ready handshake. It also has a configurable MMIO hole and a sequential initialisation engine that clears memory and loads the 16-entry seven-segment code table after reset.

---
 rtl/data_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte/half/word little-endian access, registered loads,
// MMIO hole, and a post-reset init sweep that clears RAM and loads the 7-seg table.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_BITS     = 7,
  parameter bit          TABLE_EN       = 1'b1,
  parameter logic [31:0] MMIO_BASE      = 32'h4000_0000,
  parameter int unsigned MMIO_SPAN_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        rd_valid,
  output logic [31:0] read_data,
  output logic        misalign,
  output logic        init_busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS-1:0] PTR_LAST = DEPTH_BITS'(DEPTH - 1);
  localparam logic [DEPTH_BITS-1:0] TBL_HI   = DEPTH_BITS'(DEPTH - 2);
  localparam logic [DEPTH_BITS-1:0] TBL_LO   = DEPTH_BITS'(DEPTH - 17);
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef enum logic [0:0] {S_INIT, S_READY} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_BITS-1:0] ptr_q, ptr_d;
  logic [31:0]           mem [DEPTH];

  logic                  rd_valid_q, rd_valid_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  mis_pend_q, mis_pend_d;
  logic                  misalign_q;

  // State and init pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + DEPTH_BITS'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = S_READY;
          ptr_d   = '0;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      S_INIT:  init_busy = 1'b1;
      default: req_ready = 1'b1;
    endcase
  end

  // Init word for the current pointer: table codes sit just below the top word
  logic [31:0] init_word;
  logic [3:0]  tbl_k;
  always_comb begin
    init_word = '0;
    tbl_k     = 4'(TBL_HI - ptr_q);
    if (TABLE_EN && (ptr_q >= TBL_LO) && (ptr_q <= TBL_HI)) begin
      init_word = {25'b0, SEG[tbl_k]};
    end
  end

  // Request decode
  logic                  accept, is_access, is_half, is_word, mis, mmio;
  logic                  st_we, ld_ok;
  logic [DEPTH_BITS-1:0] widx;
  logic [3:0]            be;
  logic [31:0]           wdata, rword, shifted, ld_ext;

  always_comb begin
    accept    = req_valid && req_ready;
    is_access = mem_read || mem_write;
    is_half   = (size == 2'd1);
    is_word   = size[1];
    mis       = is_access && ((is_half && address[0]) || (is_word && (address[1:0] != 2'b00)));
    mmio      = (address[31:MMIO_SPAN_BITS] == MMIO_BASE[31:MMIO_SPAN_BITS]);
    st_we     = accept && mem_write && !mis && !mmio;
    ld_ok     = accept && mem_read && !mem_write && !mis;
    widx      = address[DEPTH_BITS+1:2];

    case (size)
      2'd0: begin
        be    = 4'b0001 << address[1:0];
        wdata = {4{write_data[7:0]}};
      end
      2'd1: begin
        be    = address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = write_data;
      end
    endcase

    rword   = mmio ? 32'h0 : mem[widx];
    shifted = rword >> {address[1:0], 3'b000};
    case (size)
      2'd0:    ld_ext = {{24{!unsigned_ld && shifted[7]}}, shifted[7:0]};
      2'd1:    ld_ext = {{16{!unsigned_ld && shifted[15]}}, shifted[15:0]};
      default: ld_ext = rword;
    endcase

    rd_valid_d  = ld_ok;
    read_data_d = ld_ok ? ld_ext : 32'h0;
    mis_pend_d  = accept && mis;
  end

  // Storage array has no reset; the init sweep defines its contents
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[ptr_q] <= init_word;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Load result and error pulse; misalign lags the accept edge by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q  <= 1'b0;
      read_data_q <= '0;
      mis_pend_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      read_data_q <= read_data_d;
      mis_pend_q  <= mis_pend_d;
      misalign_q  <= mis_pend_q;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign read_data = read_data_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a byte-array reference model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        unsigned_ld = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        rd_valid;
  logic [31:0] read_data;
  logic        misalign;
  logic        init_busy;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          prev_mis = 1'b0;
  logic [7:0]  mdl [512];

  localparam logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  data_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .address(address), .write_data(write_data), .rd_valid(rd_valid), .read_data(read_data),
    .misalign(misalign), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic void model_init();
    for (int i = 0; i < 512; i++) mdl[i] = 8'h00;
    for (int k = 0; k < 16; k++) mdl[(126 - k) * 4] = SEG[k];
  endfunction

  // One request: accepted on the next rising edge, results sampled on the falling edge after it
  task automatic req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    bit          mis, mmio, exp_v;
    logic [31:0] exp_d, w;
    int          nb, base;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz;
    unsigned_ld = uns; address = addr; write_data = wd;
    @(posedge clk);
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis   = (rd || wr) && ((addr % nb) != 0);
    mmio  = (addr / 256) == (32'h4000_0000 / 256);
    base  = int'(addr % 512);
    exp_v = 1'b0;
    exp_d = 32'h0;
    if (!mis && wr && !mmio) begin
      for (int b = 0; b < nb; b++) mdl[base + b] = wd[8*b +: 8];
    end else if (!mis && rd && !wr) begin
      exp_v = 1'b1;
      if (!mmio) begin
        w = 32'h0;
        for (int b = 0; b < nb; b++) w[8*b +: 8] = mdl[base + b];
        if (!uns && nb < 4 && w[8*nb-1]) w = w - (32'h1 << (8 * nb));
        exp_d = w;
      end
    end
    @(negedge clk);
    check($sformatf("rd_valid@%08h", addr), {31'b0, rd_valid}, {31'b0, exp_v});
    check($sformatf("read_data@%08h", addr), read_data, exp_d);
    check("misalign", {31'b0, misalign}, {31'b0, prev_mis});
    prev_mis = mis;
  endtask

  task automatic idle();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("idle_read_data", read_data, 32'h0);
    check("idle_misalign", {31'b0, misalign}, {31'b0, prev_mis});
    prev_mis = 1'b0;
  endtask

  task automatic wait_init();
    int cnt = 0;
    while (cnt < 400) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 127) check("busy_at_127", {31'b0, init_busy}, 32'h1);
      if (req_ready) break;
    end
    check("init_edges", 32'(cnt), 32'd128);
    check("init_busy_done", {31'b0, init_busy}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h0);
    check("rst_init_busy", {31'b0, init_busy}, 32'h1);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    reset = 1'b1;
    model_init();
    wait_init();

    req(1, 0, 2'd2, 0, 32'h1F8, 0);
    check("table_word126", read_data, 32'h3F);
    req(1, 0, 2'd2, 0, 32'h1BC, 0);
    check("table_word111", read_data, 32'h71);
    req(1, 0, 2'd2, 0, 32'h000, 0);
    req(1, 0, 2'd2, 0, 32'h1FC, 0);

    req(0, 1, 2'd2, 0, 32'h10, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) req(1, 0, 2'd0, 0, 32'h10 + 32'(i), 0);
    for (int i = 0; i < 4; i++) req(1, 0, 2'd0, 1, 32'h10 + 32'(i), 0);
    req(0, 1, 2'd0, 0, 32'h22, 32'h000000AB);
    req(1, 0, 2'd2, 0, 32'h20, 0);
    check("byte_lane2", read_data, 32'h00AB0000);
    req(0, 1, 2'd1, 0, 32'h20, 32'h00001234);
    req(1, 0, 2'd2, 0, 32'h20, 0);
    check("half_lane0", read_data, 32'h00AB1234);

    req(0, 1, 2'd2, 0, 32'h4000_0010, 32'hCAFEF00D);
    req(1, 0, 2'd2, 0, 32'h4000_0010, 0);
    req(1, 0, 2'd2, 0, 32'h10, 0);
    check("mmio_no_alias", read_data, 32'h80FF7F01);

    req(0, 1, 2'd1, 0, 32'h05, 32'hFFFF);
    idle();
    req(1, 0, 2'd2, 0, 32'h06, 0);
    idle();
    req(1, 0, 2'd2, 0, 32'h04, 0);
    req(1, 1, 2'd2, 0, 32'h08, 32'h5555AAAA);
    req(0, 0, 2'd2, 0, 32'h0C, 0);
    req(1, 0, 2'd2, 0, 32'h08, 0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'h4000_0000 | 32'($urandom_range(0, 255));
      else if (r == 1) a = $urandom;
      else a = 32'($urandom_range(0, 511));
      r = $urandom_range(0, 7);
      if (r == 7) idle();
      else req(r < 3, (r >= 3 && r < 5) || (r == 6 && $urandom_range(0, 1) == 1),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    idle();

    req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    req(1, 0, 2'd2, 0, 32'h10, 0);
    req(1, 0, 2'd2, 0, 32'h14, 0);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; address = 32'h10;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("mid_rst_read_data", read_data, 32'h0);
    check("mid_rst_misalign", {31'b0, misalign}, 32'h0);
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'h0);
    check("mid_rst_init_busy", {31'b0, init_busy}, 32'h1);
    req_valid = 1'b0; mem_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    prev_mis = 1'b0;
    model_init();
    wait_init();
    req(1, 0, 2'd2, 0, 32'h10, 0);
    check("cleared_after_reinit", read_data, 32'h0);
    req(1, 0, 2'd2, 0, 32'h1F8, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
